rom_port_arbiter: RTL

- Shares one single-port coefficient ROM between N_REQ independent ROM readers, for example several FIFO-to-ROM fetch units.
- Each reader holds its ce/addr request until it gets a one-cycle valid; the arbiter picks one reader round-robin and drives the ROM.
- It waits for the ROM's data_valid, returns the registered data to the granted reader, then rotates priority.
- A watchdog stops a missing rom_valid from hanging the datapath.

---
 rtl/rom_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Round-robin arbiter that shares one single-port ROM among
//               N_REQ readers. It waits for the ROM's data valid and has a
//               watchdog that aborts an access whose data never arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_ce,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0]       req_data,
  output logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_W-1:0]       rom_data,
  input  logic                    rom_valid,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [2:0]              timeout_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_DELIVER = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [2:0]          ptr, ptr_nx;
  logic [2:0]          sel, sel_nx;
  logic [7:0]          cnt, cnt_nx;
  logic [N_REQ-1:0]    grant_nx, req_valid_nx;
  logic [ADDR_W-1:0]   rom_addr_nx;
  logic                rom_ce_nx, terr_nx;
  logic [DATA_W-1:0]   req_data_nx;
  logic [2:0]          tid_nx;

  // Round-robin picker outputs
  logic [7:0]          ce_ext;
  logic [3:0]          scan_idx;
  logic                pick_found;
  logic [2:0]          pick;
  logic [N_REQ-1:0]    pick_oh;
  logic [ADDR_W-1:0]   pick_addr;

  // Widened request vector so a 3-bit index is always in range
  assign ce_ext = 8'(req_ce);
  assign busy   = (state != S_IDLE);

  // Scan requesters starting at ptr, wrapping by compare-and-subtract
  always_comb begin
    pick_found = 1'b0;
    pick       = 3'd0;
    scan_idx   = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr} + 4'(k);
      if (scan_idx >= 4'(N_REQ)) begin
        scan_idx = scan_idx - 4'(N_REQ);
      end
      if (!pick_found && ce_ext[scan_idx[2:0]]) begin
        pick_found = 1'b1;
        pick       = scan_idx[2:0];
      end
    end
  end

  // One-hot grant and address mux for the picked requester
  always_comb begin
    pick_oh   = '0;
    pick_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == 3'(i)) begin
        pick_oh[i] = 1'b1;
        pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    sel_nx       = sel;
    cnt_nx       = cnt;
    grant_nx     = grant;
    req_valid_nx = req_valid;
    rom_addr_nx  = rom_addr;
    rom_ce_nx    = rom_ce;
    req_data_nx  = req_data;
    terr_nx      = timeout_err;
    tid_nx       = timeout_id;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_nx    = pick_oh;
          rom_addr_nx = pick_addr;
          rom_ce_nx   = 1'b1;
          cnt_nx      = 8'd0;
          sel_nx      = pick;
          state_nx    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Data arriving on the expiry cycle wins over the watchdog
        if (rom_valid) begin
          req_data_nx  = rom_data;
          req_valid_nx = grant;
          rom_ce_nx    = 1'b0;
          state_nx     = S_DELIVER;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          req_data_nx  = '0;
          req_valid_nx = grant;
          terr_nx      = 1'b1;
          tid_nx       = sel;
          rom_ce_nx    = 1'b0;
          state_nx     = S_DELIVER;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_DELIVER: begin
        req_valid_nx = '0;
        terr_nx      = 1'b0;
        grant_nx     = '0;
        // Served requester drops to lowest priority
        ptr_nx       = (sel == 3'(N_REQ - 1)) ? 3'd0 : sel + 3'd1;
        state_nx     = S_GAP;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= 3'd0;
      sel         <= 3'd0;
      cnt         <= 8'd0;
      grant       <= '0;
      req_valid   <= '0;
      rom_addr    <= '0;
      rom_ce      <= 1'b0;
      req_data    <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= 3'd0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      sel         <= sel_nx;
      cnt         <= cnt_nx;
      grant       <= grant_nx;
      req_valid   <= req_valid_nx;
      rom_addr    <= rom_addr_nx;
      rom_ce      <= rom_ce_nx;
      req_data    <= req_data_nx;
      timeout_err <= terr_nx;
      timeout_id  <= tid_nx;
    end
  end

endmodule
`default_nettype wire
